extest_pattern_driver: RTL and testbench

EXTEST_PATTERN_DRIVER -- requirements
Module: extest_pattern_driver

---
 rtl/extest_pattern_driver.sv | 116 +++++++++++
 tb/tb_extest_pattern_driver.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/extest_pattern_driver.sv
// extest_pattern_driver: drives one EXTEST load/capture/unload run through a wrapper boundary chain and grades the result
module extest_pattern_driver #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 clear_fail,
  input  logic                 func_en,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  output logic                 extest_mode,
  output logic                 en,
  output logic                 extest_scan_in,
  input  logic                 extest_scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] result,
  output logic [CNT_W-1:0]     fail_count
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [CHAIN_LEN-1:0] r_pat, r_exp, r_mask, r_sel;
  logic [CHAIN_LEN-1:0] w_res;
  logic w_last, w_pass;
  assign w_last = r_cnt == CW'(CHAIN_LEN - 1);
  // one-hot r_sel writes only the bit being unloaded, so an abort leaves later bits untouched
  assign w_res = (r_state == SHIFT_OUT) ? (result & ~r_sel) | ({CHAIN_LEN{extest_scan_out}} & r_sel) : result;
  assign w_pass = ((w_res ^ r_exp) & r_mask) == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_pat <= '0;
      r_exp <= '0;
      r_mask <= '0;
      r_sel <= '0;
      extest_mode <= 1'b0;
      en <= 1'b0;
      extest_scan_in <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      result <= '0;
      fail_count <= '0;
    end else begin
      done <= 1'b0;
      if (clear_fail) fail_count <= '0;
      if (abort && r_state != IDLE) begin
        r_state <= IDLE;
        extest_mode <= 1'b0;
        en <= func_en;
        extest_scan_in <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            en <= func_en;
            if (start && !abort) begin
              r_state <= SHIFT_IN;
              r_pat <= pattern >> 1;
              r_exp <= expected;
              r_mask <= mask;
              r_cnt <= '0;
              extest_mode <= 1'b1;
              en <= 1'b1;
              extest_scan_in <= pattern[0];
              busy <= 1'b1;
            end
          end
          SHIFT_IN: begin
            r_cnt <= r_cnt + 1'b1;
            r_pat <= r_pat >> 1;
            extest_scan_in <= r_pat[0];
            if (w_last) begin
              r_state <= CAPTURE;
              r_cnt <= '0;
              en <= 1'b0;
              extest_scan_in <= 1'b0;
            end
          end
          CAPTURE: begin
            r_state <= SHIFT_OUT;
            r_sel <= CHAIN_LEN'(1);
            en <= 1'b1;
          end
          SHIFT_OUT: begin
            result <= w_res;
            r_sel <= r_sel << 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DONE;
              extest_mode <= 1'b0;
              en <= 1'b0;
              done <= 1'b1;
              pass <= w_pass;
              if (!w_pass && !clear_fail && !(&fail_count)) fail_count <= fail_count + 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            busy <= 1'b0;
            en <= func_en;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_extest_pattern_driver.sv
// tb_extest_pattern_driver: directed and randomized EXTEST runs against a behavioural boundary-chain model
module tb_extest_pattern_driver;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, clear_fail = 1'b0, func_en = 1'b0;
  logic [7:0] pattern = '0, expected = '0, mask = '0;
  logic mode, en, scan_in, busy, done, pass, scan_out;
  logic [7:0] result, fc;
  logic mode2, en2, sin2, busy2, done2, pass2;
  logic [7:0] result2;
  logic [1:0] fc2;
  logic [7:0] chain = '0;
  logic [3:0] cap_nib = '0;
  int n_cmp = 0, n_err = 0;
  int m_fc8 = 0, m_fc2 = 0;
  logic [7:0] last_res;
  always #5 clk = ~clk;
  extest_pattern_driver dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .clear_fail(clear_fail),
    .func_en(func_en), .pattern(pattern), .expected(expected), .mask(mask),
    .extest_mode(mode), .en(en), .extest_scan_in(scan_in), .extest_scan_out(scan_out),
    .busy(busy), .done(done), .pass(pass), .result(result), .fail_count(fc)
  );
  extest_pattern_driver #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .clear_fail(clear_fail),
    .func_en(func_en), .pattern(pattern), .expected(expected), .mask(mask),
    .extest_mode(mode2), .en(en2), .extest_scan_in(sin2), .extest_scan_out(scan_out),
    .busy(busy2), .done(done2), .pass(pass2), .result(result2), .fail_count(fc2)
  );
  // wrapper chain: shift toward bit 0 when enabled, capture the low nibble from the "pins" otherwise
  always @(posedge clk)
    if (mode && en) chain <= {scan_in, chain[7:1]};
    else if (mode) chain[3:0] <= cap_nib;
  assign scan_out = chain[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] pat, input logic [7:0] ex, input logic [7:0] msk,
                     input logic [3:0] nib, input bit busy_start, input bit clr);
    logic [7:0] sin_seq, want;
    logic [9:0] en_seq;
    logic [16:0] mode_seq;
    int lat, dones;
    bit fail;
    want = {pat[7:4], nib};
    fail = ((want ^ ex) & msk) != 8'h00;
    @(negedge clk);
    pattern = pat; expected = ex; mask = msk; cap_nib = nib; start = 1'b1; clear_fail = clr;
    lat = 0; dones = 0; sin_seq = '0; en_seq = '0; mode_seq = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = busy_start && c == 5;
      if (busy_start && c == 5) pattern = ~pat;
      if (c <= 8) sin_seq[c-1] = scan_in;
      if (c <= 10) en_seq[c-1] = en;
      if (c <= 17) mode_seq[c-1] = mode;
      if (done) begin
        dones++;
        if (lat == 0) lat = c;
      end
      if (lat != 0 && c >= lat + 3) break;
    end
    clear_fail = 1'b0;
    if (clr) begin
      m_fc8 = 0; m_fc2 = 0;
    end else if (fail) begin
      m_fc8 = (m_fc8 < 255) ? m_fc8 + 1 : 255;
      m_fc2 = (m_fc2 < 3) ? m_fc2 + 1 : 3;
    end
    chk("latency", lat, 18);
    chk("done_pulses", dones, 1);
    chk("scan_in_seq", sin_seq, pat);
    chk("en_seq", en_seq, 10'h2FF);
    chk("mode_seq", mode_seq, 17'h1FFFF);
    chk("result", result, want);
    chk("pass", pass, !fail);
    chk("fail_count", fc, m_fc8);
    chk("fail_count_sat", fc2, m_fc2);
    chk("idle_after", {busy, mode}, 2'b00);
    last_res = want;
  endtask

  initial begin
    logic [7:0] p, e, w;
    logic [3:0] nb;
    int dones;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {mode, en, scan_in, busy, done, pass}, 6'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_fc", fc, 8'h00);
    chk("rst_fc2", fc2, 2'b00);
    reset = 1'b0;
    @(negedge clk); func_en = 1'b1;
    @(negedge clk); chk("func_en_hi", {en, mode, scan_in}, 3'b100);
    func_en = 1'b0;
    @(negedge clk); chk("func_en_lo", en, 1'b0);
    run(8'hA5, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
    run(8'h5C, 8'h53, 8'hFF, 4'h3, 1'b0, 1'b0);
    run(8'h5C, 8'h50, 8'hF0, 4'h3, 1'b0, 1'b0);
    run(8'h5C, 8'h50, 8'hFF, 4'h3, 1'b0, 1'b0);
    run(8'h3A, 8'h00, 8'h00, 4'h7, 1'b1, 1'b0);
    func_en = 1'b1;
    @(negedge clk); pattern = 8'h96; cap_nib = 4'h1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle", {mode, busy, en, scan_in}, 4'b0010);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_pass_kept", pass, 1'b1);
    chk("abort_result_kept", result, last_res);
    chk("abort_fc_kept", fc, m_fc8);
    func_en = 1'b0;
    repeat (4) begin
      p = 8'($urandom); nb = 4'($urandom);
      run(p, ~{p[7:4], nb}, 8'hFF, nb, 1'b0, 1'b0);
    end
    p = 8'($urandom); nb = 4'($urandom);
    run(p, ~{p[7:4], nb}, 8'hFF, nb, 1'b0, 1'b1);
    repeat (12) begin
      p = 8'($urandom); nb = 4'($urandom);
      w = {p[7:4], nb};
      e = ($urandom_range(0, 1) == 1) ? w ^ (8'($urandom) & 8'h81) : 8'($urandom);
      run(p, e, 8'($urandom), nb, 1'b0, 1'b0);
    end
    run(8'h0F, 8'hFF, 8'hFF, 4'h0, 1'b0, 1'b0);
    func_en = 1'b1;
    @(negedge clk); pattern = 8'hC3; cap_nib = 4'hE; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_shift_out", {mode, en, busy}, 3'b111);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", {mode, en, scan_in, busy, done, pass}, 6'b0);
    chk("rst_mid_result", result, 8'h00);
    chk("rst_mid_fc", {fc, fc2}, 10'h000);
    reset = 1'b0; func_en = 1'b0;
    m_fc8 = 0; m_fc2 = 0;
    run(8'h69, 8'h6B, 8'hFF, 4'hB, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
